// File: rtl/hazard_unit.sv
// Hazard controller: forwarding, load-use/branch stall-flush and fixed-latency memory freeze.
// Define HAZARD_MEMWAIT_EN to compile in the memory wait sequencer.
module hazard_unit #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        PCSrcD,
  input  logic        PCSrcE,
  input  logic        PCSrcM,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemBusy,
  output logic [31:0] StallCount
);

  logic ldr_stall;
  logic pc_wr_pending;
  logic mem_stall;

  // M-stage ALU result takes priority over the W-stage result.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
  end

  assign ldr_stall     = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

`ifdef HAZARD_MEMWAIT_EN
  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              access;

  assign access = MemtoRegM || MemWriteM;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && (WAIT_CYCLES > 0)) begin
          state_d   = StBusy;
          cnt_d     = CntW'(WAIT_CYCLES - 1);
          mem_stall = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CntW'(1);
          mem_stall = 1'b1;
        end else begin
          // Release cycle: stalls drop so the access leaves M on the next edge.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MemBusy = (state_q == StBusy);
`else
  logic unused_mem;

  assign unused_mem = ^{MemtoRegM, MemWriteM, 32'(WAIT_CYCLES)};
  assign mem_stall  = 1'b0;
  assign MemBusy    = 1'b0;
`endif

  // Frozen stages keep their contents, so no D/E flush while memory stalls.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall || pc_wr_pending;
      StallD = ldr_stall;
      FlushD = pc_wr_pending || PCSrcW || BranchTakenE;
      FlushE = ldr_stall || BranchTakenE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= '0;
    end else if (StallF) begin
      StallCount <= StallCount + 32'd1;
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard controller for the five-stage pipelined ARM core. It drives the stall and flush enables of the F/D/E/M/W pipeline registers and the E-stage ALU operand forwarding muxes. It also sequences fixed-latency data-memory accesses by freezing the pipeline while a load or store occupies M. It keeps a free-running stall-cycle counter for performance measurement.

## Interface
Parameters:
- WAIT_CYCLES, default 2: number of extra cycles a memory access holds the M stage; 0 means single-cycle memory.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- RA1D, RA2D  in  4  source registers of the instruction in D
- RA1E, RA2E  in  4  source registers of the instruction in E
- WA3E, WA3M, WA3W  in  4  destination registers in E, M and W
- RegWriteM, RegWriteW  in  1  register-file write pending in M and in W
- MemtoRegE, MemtoRegM  in  1  load in E and load in M
- MemWriteM  in  1  store in M
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction in that stage writes the PC
- BranchTakenE  in  1  branch resolved taken in E
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 result from W, 10 ALU result from M
- StallF, StallD, StallE, StallM  out  1  hold the F, D, E and M pipeline registers
- FlushD, FlushE, FlushW  out  1  load a bubble into the D, E and W registers
- MemBusy  out  1  memory sequencer is not IDLE
- StallCount  out  32  number of cycles with StallF=1

## Operation
- Forwarding (combinational): ForwardAE=10 if RegWriteM and RA1E==WA3M; else 01 if RegWriteW and RA1E==WA3W; else 00. ForwardBE uses the same rule with RA2E. M has priority over W.
- Load-use: LDRstall = MemtoRegE and (RA1D==WA3E or RA2D==WA3E).
- PCWrPending = PCSrcD or PCSrcE or PCSrcM.
- Memory sequencer states:
  - IDLE: if access (MemtoRegM or MemWriteM) and WAIT_CYCLES>0, go to BUSY and load cnt with WAIT_CYCLES-1.
  - BUSY with cnt!=0: decrement cnt.
  - BUSY with cnt==0: this is the release cycle; go to IDLE.
- MemStall = (IDLE and access and WAIT_CYCLES>0) or (BUSY and cnt!=0). An access therefore occupies M for WAIT_CYCLES+1 cycles.
- Outputs while MemStall=1:
  - StallF, StallD, StallE, StallM = 1.
  - FlushW = 1.
  - FlushD, FlushE = 0, because frozen stages keep their contents.
- Outputs while MemStall=0:
  - StallE, StallM, FlushW = 0.
  - StallF = LDRstall or PCWrPending.
  - StallD = LDRstall.
  - FlushD = PCWrPending or PCSrcW or BranchTakenE.
  - FlushE = LDRstall or BranchTakenE.
- Invariant: PCSrcW cannot coincide with MemStall, because PCWrPending fills D/E/M with bubbles. The bench checks this invariant with an assertion.
- StallCount increments on every cycle with StallF=1 and wraps from 2^32-1 to 0.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state, with no added latency.
- State, cnt and StallCount update on the rising edge of clk.
- Reset (asynchronous, any cycle, including mid-access):
  - State goes to IDLE, cnt to 0, StallCount to 0, MemBusy to 0.
  - With all inputs 0, every output is 0.
- Release cycle: MemBusy=1 and all stalls are deasserted. The access leaves M on the next edge. A back-to-back access entering M then re-triggers from IDLE.
- A load-use hazard during MemStall is held. LDRstall takes effect on the first non-stalled cycle.
- A taken branch held in E during MemStall flushes D and E in the release cycle.

## Configuration
- HAZARD_MEMWAIT_EN defined: the memory sequencer, cnt, MemBusy and the MemStall terms are compiled in.
- HAZARD_MEMWAIT_EN undefined: the sequencer is absent and WAIT_CYCLES is ignored. MemStall is 0, and StallE, StallM, FlushW and MemBusy are tied to 0. Forwarding, hazard logic and StallCount are unchanged.

## Test plan
- Forwarding: RegWriteM=1, WA3M=5, RegWriteW=1, WA3W=5, RA1E=5, RA2E=5 -> ForwardAE=10, ForwardBE=10. Drop RegWriteM -> both 01.
- Load-use: MemtoRegE=1, WA3E=3, RA2D=3 -> StallF=1, StallD=1, FlushE=1 for exactly one cycle; StallCount increments by 1.
- Branch: BranchTakenE=1 -> FlushD=1, FlushE=1, StallF=0. PCSrcD=1 -> StallF=1, FlushD=1 for each cycle PCSrc sits in D, E and M.
- Memory wait with WAIT_CYCLES=2: a load enters M -> StallF/D/E/M=1 and FlushW=1 for 2 cycles, then the release cycle with MemBusy=1 and stalls 0, then IDLE. A second load entering M immediately after -> another 2 stall cycles.
- Reset mid-access: assert reset_n=0 while BUSY with cnt=1 -> all outputs 0 at once, StallCount=0, state IDLE after release.
- HAZARD_MEMWAIT_EN undefined: repeat the memory-wait test -> no stalls, StallE=StallM=FlushW=MemBusy=0 throughout.
